// File: rtl/y_divider.sv
// y_divider: multi-cycle restoring divider (quotient/remainder) with valid/ready handshakes.
// One trial subtraction per cycle; one operation in flight at a time.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready          operand handshake (dividend, divisor)
//   out_valid/out_ready        result handshake (quotient, remainder, div_by_zero)
//   div_by_zero                current result came from divisor == 0
//
// Optional feature: define Y_DIVIDER_SIGNED_EN for two's-complement operands
// (truncating division). Undefined, the block is strictly unsigned.
module y_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int unsigned      CNT_W   = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CntInit = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, q_q, d_q;
    logic [WIDTH-1:0] quot_q, rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dbz_q;

    logic             accept;
    logic             last_step;
    logic             divisor_zero;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] diff;
    logic [WIDTH-1:0] a_step, q_step;
    logic [WIDTH-1:0] q_fin, r_fin;

    assign divisor_zero = (divisor == '0);
    assign last_step    = (cnt_q == CntLast);

    // One restoring step. The shifted partial remainder can need WIDTH+1 bits,
    // so the trial subtraction carries one extra bit to expose the borrow.
    always_comb begin
        rem_sh = {a_q, q_q[WIDTH-1]};
        diff   = {1'b0, rem_sh} - {2'b00, d_q};
        q_step = {q_q[WIDTH-2:0], ~diff[WIDTH+1]};
        a_step = diff[WIDTH+1] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    end

`ifdef Y_DIVIDER_SIGNED_EN
    logic neg_quot_q, neg_rem_q;

    always_comb begin
        dvd_mag = dividend[WIDTH-1] ? ('0 - dividend) : dividend;
        dvs_mag = divisor[WIDTH-1] ? ('0 - divisor) : divisor;
        q_fin   = neg_quot_q ? ('0 - q_step) : q_step;
        r_fin   = neg_rem_q ? ('0 - a_step) : a_step;
    end

    // Remainder follows the dividend's sign (truncation toward zero).
    always_ff @(posedge clk) begin
        if (reset) begin
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else if (accept) begin
            neg_quot_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_q  <= dividend[WIDTH-1];
        end
    end
`else
    always_comb begin
        dvd_mag = dividend;
        dvs_mag = divisor;
        q_fin   = q_step;
        r_fin   = a_step;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = divisor_zero ? StDone : StRun;
            StRun:   if (last_step) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready    = (state_q == StIdle);
        out_valid   = (state_q == StDone);
        accept      = in_valid && in_ready;
        quotient    = quot_q;
        remainder   = rem_q;
        div_by_zero = dbz_q;
    end

    // Datapath. Results are registered on the last RUN step so they are
    // stable for the whole DONE state.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            q_q    <= '0;
            d_q    <= '0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dbz_q  <= 1'b0;
        end else if (accept) begin
            a_q   <= '0;
            q_q   <= dvd_mag;
            d_q   <= dvs_mag;
            cnt_q <= CntInit;
            dbz_q <= divisor_zero;
            if (divisor_zero) begin
                quot_q <= '1;
                rem_q  <= dividend;
            end
        end else if (state_q == StRun) begin
            a_q   <= a_step;
            q_q   <= q_step;
            cnt_q <= cnt_q - 1'b1;
            if (last_step) begin
                quot_q <= q_fin;
                rem_q  <= r_fin;
            end
        end
    end

endmodule

// File: tb/tb_y_divider.sv
`timescale 1ns/1ps
module tb_y_divider;
    localparam int unsigned W = 32;
    localparam logic [W-1:0] ALL1 = '1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         in_ready, out_valid, div_by_zero;
    logic [W-1:0] quotient, remainder;

    y_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: plain arithmetic on the operands.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
`ifdef Y_DIVIDER_SIGNED_EN
        longint sa, sb;
`endif
        z = (b == '0);
        if (z) begin
            q = '1;
            r = a;
        end else begin
`ifdef Y_DIVIDER_SIGNED_EN
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
`else
            q = a / b;
            r = a % b;
`endif
        end
    endfunction

    // Single-op model of the block, checked every cycle out of reset.
    logic         busy = 1'b0;
    logic         ov_exp;
    int           acc_n = 0;
    int           exp_lat = 0;
    logic [W-1:0] mq, mr;
    logic         mz;
    int           acc_log[$];

    always @(negedge clk) begin
        if (reset) begin
            busy = 1'b0;
        end else begin
            check("in_ready", in_ready, !busy);
            ov_exp = busy && (cyc - acc_n >= exp_lat);
            check("out_valid", out_valid, ov_exp);
            if (ov_exp) begin
                check("quotient", quotient, mq);
                check("remainder", remainder, mr);
                check("div_by_zero", div_by_zero, mz);
            end
            if (ov_exp && out_ready) begin
                busy = 1'b0;
            end else if (!busy && in_valid) begin
                model(dividend, divisor, mq, mr, mz);
                exp_lat = mz ? 1 : W + 1;
                acc_n   = cyc;
                busy    = 1'b1;
                acc_log.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        check("in_ready_wait", in_ready, 1'b1);
    endtask

    // Issue one op, then wait for out_valid; lat counts the accept edge as 1.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat,
                          output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        wait_ready();
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        lat = 1;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        q = quotient;
        r = remainder;
        z = div_by_zero;
    endtask

    function automatic logic [W-1:0] rand_opnd();
        logic [W-1:0] v;
        v = $urandom;
        return v >> $urandom_range(0, W - 1);
    endfunction

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int           lat, base;
        logic [W-1:0] q, r;
        logic         z;

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_quotient", quotient, 0);
        check("rst_div_by_zero", div_by_zero, 1'b0);

        // 100 / 7
        out_ready = 1'b1;
        run_op(32'd100, 32'd7, lat, q, r, z);
        check("lat_100_7", lat, W + 1);
        check("q_100_7", q, 14);
        check("r_100_7", r, 2);
        check("z_100_7", z, 1'b0);

        // Divide by zero, then a normal op clears the flag
        run_op(32'd5, 32'd0, lat, q, r, z);
        check("lat_div0", lat, 1);
        check("q_div0", q, ALL1);
        check("r_div0", r, 5);
        check("z_div0", z, 1'b1);
        run_op(32'd9, 32'd3, lat, q, r, z);
        check("q_9_3", q, 3);
        check("r_9_3", r, 0);
        check("z_9_3", z, 1'b0);
        tick();

        // Output stall with an ignored in_valid pulse
        out_ready = 1'b0;
        run_op(ALL1, 32'd1, lat, q, r, z);
        check("lat_max_1", lat, W + 1);
        check("q_max_1", q, ALL1);
        check("r_max_1", r, 0);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i == 3);
            dividend = 32'd8;
            divisor  = 32'd2;
            tick();
            check("stall_out_valid", out_valid, 1'b1);
            check("stall_quotient", quotient, ALL1);
            check("stall_remainder", remainder, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("post_stall_in_ready", in_ready, 1'b1);

        // Reset mid-RUN aborts the op
        wait_ready();
        in_valid = 1'b1;
        dividend = 32'd1234;
        divisor  = 32'd5;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_div_by_zero", div_by_zero, 1'b0);
        repeat (W + 8) tick();
        check("abort_no_result", out_valid, 1'b0);

        // Back-to-back with in_valid held high
        base      = acc_log.size();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            dividend = $urandom;
            divisor  = rand_opnd();
            if (divisor == '0) divisor = 32'd1;
            wait_ready();
            tick();
        end
        in_valid = 1'b0;
        wait_ready();
        check("b2b_accepts", acc_log.size() - base, 10);
        for (int k = 1; k < 10 && base + k < acc_log.size(); k++) begin
            check("b2b_interval", acc_log[base+k] - acc_log[base+k-1], W + 2);
        end

        // Free-running random traffic
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 2) == 0);
            dividend  = rand_opnd();
            case ($urandom_range(0, 7))
                0:       divisor = '0;
                1:       divisor = dividend + 32'd1;
                2:       divisor = $urandom_range(1, 15);
                default: divisor = rand_opnd();
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_ready();

`ifdef Y_DIVIDER_SIGNED_EN
        run_op(32'hFFFF_FFF9, 32'd2, lat, q, r, z);
        check("s_q_m7_2", q, 32'hFFFF_FFFD);
        check("s_r_m7_2", r, 32'hFFFF_FFFF);
        run_op(32'd7, 32'hFFFF_FFFE, lat, q, r, z);
        check("s_q_7_m2", q, 32'hFFFF_FFFD);
        check("s_r_7_m2", r, 1);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, lat, q, r, z);
        check("s_q_ovf", q, 32'h8000_0000);
        check("s_r_ovf", r, 0);
        check("s_z_ovf", z, 1'b0);
        check("s_lat_ovf", lat, W + 1);
        wait_ready();
`endif

        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
